// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Width of the hold counter; an unlimited hold still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_decoder_arbiter_if #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) ();
    import arb_pkg::*;

    localparam int unsigned ADDR_WIDTH = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_WIDTH  = cnt_width(MAX_HOLD);

    logic                  en;
    logic [N-1:0]          req;
    logic [N-1:0]          grant;
    logic [ADDR_WIDTH-1:0] grant_idx;
    logic                  grant_valid;
    logic [CNT_WIDTH-1:0]  hold_cnt;

    // Requester side.
    modport master (
        output en,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output hold_cnt
    );

endinterface

// File: rtl/decoder_logN_to_N.sv
// Binary index to one-hot decoder with enable; out-of-range addresses decode to zero.
module decoder_logN_to_N #(
    parameter int unsigned N = 8
) (
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] addr,
    input  logic                                 en,
    output logic [N-1:0]                         dout
);

    // One-hot decode, all zero when disabled.
    always_comb begin
        dout = '0;
        if (en) begin
            dout = N'(1) << addr;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with hold limit and a one-cycle dead gap on every owner change.
module rr_decoder_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    rr_decoder_arbiter_if.slave bus
);
    import arb_pkg::*;

    localparam int unsigned ADDR_WIDTH = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_WIDTH  = cnt_width(MAX_HOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT =
        (MAX_HOLD != 0) ? CNT_WIDTH'(MAX_HOLD - 1) : {CNT_WIDTH{1'b1}};

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH:0]   pick;
    logic                  found;
    logic [ADDR_WIDTH-1:0] sel;
    logic [ADDR_WIDTH-1:0] sel_next;
    logic [N-1:0]          owner_mask;
    logic                  owner_req;
    logic                  others_req;

    // Rotating-priority scan starting at p; returns {found, index}.
    function automatic logic [ADDR_WIDTH:0] rr_pick(input logic [N-1:0]          r,
                                                    input logic [ADDR_WIDTH-1:0] p);
        logic                  hit;
        logic [ADDR_WIDTH-1:0] idx;
        int unsigned           cand;
        hit = 1'b0;
        idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(p) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!hit && ((r & (N'(1) << cand)) != '0)) begin
                hit = 1'b1;
                idx = ADDR_WIDTH'(cand);
            end
        end
        return {hit, idx};
    endfunction

    // Candidate owner, its successor pointer, and request status around the current owner.
    always_comb begin
        pick       = rr_pick(bus.req, ptr_q);
        found      = pick[ADDR_WIDTH];
        sel        = pick[ADDR_WIDTH-1:0];
        sel_next   = (sel == ADDR_WIDTH'(N - 1)) ? '0 : sel + ADDR_WIDTH'(1);
        owner_mask = N'(1) << idx_q;
        owner_req  = |(bus.req & owner_mask);
        others_req = |(bus.req & ~owner_mask);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        cnt_d   = '0;
        case (state_q)
            IDLE, GAP: begin
                if (bus.en && found) begin
                    state_d = OWN;
                    idx_d   = sel;
                    ptr_d   = sel_next;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!bus.en || !owner_req) begin
                    state_d = GAP;
                end else if ((MAX_HOLD != 0) && (cnt_q == CNT_SAT) && others_req) begin
                    state_d = GAP;
                end else begin
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.hold_cnt    = cnt_q;

    // One-hot grant straight from the registered owner.
    decoder_logN_to_N #(.N(N)) u_dec (
        .addr (idx_q),
        .en   (valid_q),
        .dout (bus.grant)
    );

endmodule
